uart_word_serializer: RTL and testbench



---
 rtl/uart_word_serializer.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_word_serializer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_serializer.sv
// uart_word_serializer
// Buffers 32-bit result words in a small FIFO and emits each one as four
// bytes, least-significant byte first, to a byte-wide UART transmitter
// using a one-cycle tx_start pulse and the transmitter's tx_busy flag.
//
// Build option: define SER_SYNC_BYTE_EN to precede every word with the
// sync byte 8'hA5, which gives five tx_start pulses per word.
module uart_word_serializer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    tx_byte,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic [CW-1:0] fifo_count,
  output logic          idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef SER_SYNC_BYTE_EN
  localparam logic [2:0] S_SYNC = 3'd5;
`endif

  // FIFO storage and bookkeeping
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  // Serializer state
  logic [2:0]    state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_start_q, tx_start_d;
  logic          idle_q, idle_d;
  logic          data_phase;

`ifdef SER_SYNC_BYTE_EN
  logic          sync_pend_q, sync_pend_d;
`endif

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == S_LOAD);
  assign head       = mem_q[rd_ptr_q];

  assign tx_byte    = tx_byte_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign idle       = idle_q;

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO word storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef SER_SYNC_BYTE_EN
  // Remembers that the handshake in flight belongs to the sync byte.
  always_comb begin
    if (state_q == S_LOAD) begin
      sync_pend_d = 1'b1;
    end else if ((state_q == S_DONE) && !tx_busy) begin
      sync_pend_d = 1'b0;
    end else begin
      sync_pend_d = sync_pend_q;
    end
  end
  assign data_phase = !sync_pend_q;
`else
  assign data_phase = 1'b1;
`endif

  // Serializer FSM: next state, shift register, byte index and the byte
  // presented on the edge that enters SEND (tx_byte then holds until the
  // next SEND).
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    tx_byte_d  = tx_byte_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shift_d    = head;
        byte_idx_d = 2'd0;
`ifdef SER_SYNC_BYTE_EN
        state_d    = S_SYNC;
        tx_byte_d  = 8'hA5;
`else
        state_d    = S_SEND;
        tx_byte_d  = head[7:0];
`endif
      end
`ifdef SER_SYNC_BYTE_EN
      S_SYNC: begin
        state_d = S_ACK;
      end
`endif
      S_SEND: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (tx_busy) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ACK;
        end
      end
      S_DONE: begin
        if (tx_busy) begin
          state_d = S_DONE;
        end else if (!data_phase) begin
          // Sync byte finished: send byte 0 without shifting.
          state_d   = S_SEND;
          tx_byte_d = shift_q[7:0];
        end else if (byte_idx_q != 2'd3) begin
          state_d    = S_SEND;
          shift_d    = {8'h00, shift_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          tx_byte_d  = shift_q[15:8];
        end else if (count_q != {CW{1'b0}}) begin
          // Next word already waiting: go straight to LOAD, skipping IDLE.
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered strobes: tx_start is high exactly in the cycle spent in a
  // byte-issuing state; idle reflects empty FIFO with the FSM parked.
  always_comb begin
`ifdef SER_SYNC_BYTE_EN
    tx_start_d = (state_d == S_SEND) || (state_d == S_SYNC);
`else
    tx_start_d = (state_d == S_SEND);
`endif
    idle_d = (count_d == {CW{1'b0}}) && (state_d == S_IDLE);
  end

  // State registers; reset drops any partial word and empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      state_q     <= S_IDLE;
      shift_q     <= 32'h0000_0000;
      byte_idx_q  <= 2'd0;
      tx_byte_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      idle_q      <= 1'b1;
`ifdef SER_SYNC_BYTE_EN
      sync_pend_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_start_q  <= tx_start_d;
      idle_q      <= idle_d;
`ifdef SER_SYNC_BYTE_EN
      sync_pend_q <= sync_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_word_serializer.sv
// Directed bench for uart_word_serializer with a transmitter model that
// holds tx_busy for 10 cycles per accepted byte (or indefinitely while
// stall is set). Works with and without SER_SYNC_BYTE_EN.
module tb_uart_word_serializer;

`ifdef SER_SYNC_BYTE_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic [2:0]  fifo_count;
  logic        idle;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_cnt = 0;
  bit stall = 1'b0;

  logic [7:0] bytes_q[$];
  int         cyc_q[$];
  logic [7:0] exp_q[$];

  uart_word_serializer #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_byte(tx_byte), .tx_start(tx_start),
    .tx_busy(tx_busy), .fifo_count(fifo_count), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model, updated away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else if (tx_start) busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    tx_busy = (busy_cnt != 0) || stall;
  end

  // Byte capture.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      bytes_q.push_back(tx_byte);
      cyc_q.push_back(cyc);
    end
  end

  task automatic push_word(input logic [31:0] w, output int acc);
    bit ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    acc = cyc;
    in_valid = 1'b0;
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL push_accept word=%h: accepted=%0b required=1", w, ok);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (idle === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle_return: idle=%b required=1", tag, idle);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    if (SYNC != 0) exp_q.push_back(8'hA5);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic clear_capture();
    bytes_q.delete();
    cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
    vectors++;
    if (tx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_tx_byte: got %h required 00", tx_byte); end
    vectors++;
    if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_fifo_count: got %0d required 0", fifo_count); end
    vectors++;
    if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b required 1", idle); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int acc;
    bit seen = 1'b0;
    clear_capture();
    push_word(32'h0000_00AA, acc);
    push_word(32'h0000_0055, acc);
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bytes_q.size() >= 1 + SYNC) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (tx_byte !== 8'hAA || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL async_pre_state: tx_byte=%h fifo_count=%0d required AA/1", tx_byte, fifo_count);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_byte !== 8'h00 || tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL async_clear_tx: tx_byte=%h tx_start=%b required 00/0", tx_byte, tx_start);
    end
    vectors++;
    if (fifo_count !== 3'd0 || idle !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_clear_fifo: count=%0d idle=%b in_ready=%b required 0/1/1", fifo_count, idle, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_capture();
  endtask

  task automatic test_single_word();
    int acc;
    clear_capture();
    push_word(32'h1122_3344, acc);
    expect_word(32'h1122_3344);
    wait_idle("single");
    vectors++;
    if (bytes_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_byte_count: got %0d required %0d", bytes_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (bytes_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL single_byte[%0d]: got %h required %h", i, bytes_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (cyc_q[0] - acc != 2) begin
        miscompares++;
        $display("FAIL single_latency: got %0d cycles required 2", cyc_q[0] - acc);
      end
    end
    vectors++;
    if (busy_cnt != 0) begin
      miscompares++;
      $display("FAIL single_idle_after_busy: busy_cnt=%0d required 0", busy_cnt);
    end
  endtask

  task automatic test_full_fifo();
    int acc;
    logic [31:0] w;
    clear_capture();
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      expect_word(w);
      if (i < 5) push_word(w, acc);
    end
    vectors++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state: count=%0d in_ready=%b required 4/0", fifo_count, in_ready);
    end
    in_data  = 32'h1716_1514;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_hold_off: count=%0d in_ready=%b required 4/0", fifo_count, in_ready);
    end
    stall = 1'b0;
    push_word(32'h1716_1514, acc);
    wait_idle("full");
    vectors++;
    if (bytes_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL full_byte_count: got %0d required %0d", bytes_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (bytes_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL full_byte[%0d]: got %h required %h", i, bytes_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int k;
    clear_capture();
    push_word(32'hDEAD_BEEF, acc);
    push_word(32'h0102_0304, acc);
    expect_word(32'hDEAD_BEEF);
    expect_word(32'h0102_0304);
    wait_idle("b2b");
    vectors++;
    if (bytes_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_byte_count: got %0d required %0d", bytes_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (bytes_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b_byte[%0d]: got %h required %h", i, bytes_q[i], exp_q[i]);
        end
      end
      // Word boundary costs exactly one LOAD cycle over an in-word step.
      k = 3 + SYNC;
      vectors++;
      if (cyc_q[k+1] - cyc_q[k] != cyc_q[k] - cyc_q[k-1] + 1) begin
        miscompares++;
        $display("FAIL b2b_no_idle_gap: boundary gap %0d required %0d",
                 cyc_q[k+1] - cyc_q[k], cyc_q[k] - cyc_q[k-1] + 1);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int acc;
    bit seen = 1'b0;
    clear_capture();
    push_word(32'hCAFE_F00D, acc);
    push_word(32'h1111_1111, acc);
    push_word(32'h2222_2222, acc);
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bytes_q.size() >= 2 + SYNC) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_progress: bytes=%0d required %0d", bytes_q.size(), 2 + SYNC);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_capture();
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (bytes_q.size() != 0 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL midreset_quiet: pulses=%0d count=%0d required 0/0", bytes_q.size(), fifo_count);
    end
    push_word(32'h0000_00FF, acc);
    expect_word(32'h0000_00FF);
    wait_idle("midreset");
    vectors++;
    if (bytes_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midreset_byte_count: got %0d required %0d", bytes_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (bytes_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL midreset_byte[%0d]: got %h required %h", i, bytes_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_sync_byte();
    int acc;
    clear_capture();
    push_word(32'h0000_0001, acc);
    expect_word(32'h0000_0001);
    wait_idle("sync");
    vectors++;
    if (bytes_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL sync_byte_count: got %0d required %0d", bytes_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (bytes_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL sync_byte[%0d]: got %h required %h", i, bytes_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_async_reset();
    test_full_fifo();
    test_back_to_back();
    test_reset_mid_word();
    test_sync_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
